regfile_burst_decoder: RTL and testbench
========================================

# regfile_burst_decoder

Parametrised, clocked write-port decoder for the register file. It accepts a write request (start address, beat count, data) over a valid/ready handshake. It then drives a one-hot write-enable vector for one register per cycle, stepping through consecutive addresses with wrap-around. It sits between the write-request source and the register array, and replaces the fixed 2-to-4 combinational enable decode with bursts (single write, region fill/clear), stall control and optional register-0 write protection.

## Interface
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- DATA_W, 8, write-data width
- ZERO_PROTECT, 0, if 1, beats addressed to register 0 never assert wr_en
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  beat enable; low stalls an active burst
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only when idle
- req_addr  in  ADDR_W  first register of the burst
- req_count  in  ADDR_W  number of beats minus 1 (0..DEPTH-1)
- req_data  in  DATA_W  value written on every beat of the burst
- wr_en  out  DEPTH  one-hot write enable (or all zero), registered
- wr_addr  out  ADDR_W  encoded address of the current beat, registered
- wr_data  out  DATA_W  data of the current beat, registered
- busy  out  1  high while a burst is active

## Operation
- States: IDLE, BURST.
- IDLE: req_ready=1, busy=0. A request is accepted on a rising edge with req_valid=1.
  - Acceptance is independent of en.
  - Acceptance captures cur_addr=req_addr, remaining=req_count, data=req_data, and moves to BURST.
- BURST: req_ready=0, busy=1. req_valid is ignored.
- On each rising edge in BURST with en=1 (one beat issued):
  - wr_en <= onehot(cur_addr); wr_addr <= cur_addr; wr_data <= data.
  - cur_addr <= (cur_addr+1) mod DEPTH. Wrap from DEPTH-1 to 0; no overflow flag.
  - If remaining==0, this is the final beat: go to IDLE. Otherwise remaining <= remaining-1.
- On a rising edge in BURST with en=0:
  - wr_en <= 0.
  - cur_addr, remaining, wr_addr and wr_data hold.
- On any edge where no beat is issued (IDLE, or a stall), wr_en <= 0.
  - wr_addr and wr_data hold their last values.
- ZERO_PROTECT=1: a beat with cur_addr==0 drives wr_en all zero.
  - That beat still updates wr_addr/wr_data, consumes remaining and advances the address.
- req_count=DEPTH-1 writes every register exactly once, starting at req_addr.
- wr_en has at most one bit set in every cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0.
  - req_ready=1, since req_ready is decoded from state.
- Reset mid-burst aborts the burst immediately: wr_en goes to 0 without waiting for a clock edge, and no further beats are issued.
- Latency, no stalls:
  - Request accepted at edge E0.
  - Beat i is visible on wr_en in the cycle after edge E0+1+i.
  - busy rises after E0 and falls after the final-beat edge.
- req_ready returns high in the same cycle the final beat is visible.
  - The next request is accepted at the end of that cycle.
  - Its first beat appears one cycle later, giving exactly one wr_en-idle cycle between back-to-back bursts.
- Each beat's wr_en is high for exactly one cycle.
- An en=0 cycle inserts one zero cycle on wr_en and delays all later beats by one cycle.

## Test plan
Default parameters (ADDR_W=2, DATA_W=8) unless stated.
- Reset with rst_n=0 -> wr_en=0000, wr_addr=0, wr_data=0x00, req_ready=1, busy=0. Release reset, hold req_valid=0 -> outputs unchanged.
- Single write (addr=2, count=0, data=0xA5, en=1) -> one cycle of wr_en=0100, wr_addr=2, wr_data=0xA5. busy is high for 1 cycle, then wr_en=0000 and wr_data holds 0xA5.
- Wrap burst (addr=3, count=2, data=0x3C) -> wr_en 1000, 0010... precisely 1000, 0001, 0010 on consecutive cycles. req_ready=0 throughout, then 1. A second request offered while busy is not accepted.
- Stall (addr=0, count=3, data=0x11; en=0 for 2 cycles after the second beat) -> wr_en 0001, 0010, 0000, 0000, 0100, 1000. busy stays high across the stall.
- ZERO_PROTECT=1 (addr=3, count=1, data=0xFF) -> wr_en 1000, then 0000 with wr_addr=0. busy falls after 2 beats, and register 0 is never enabled.
- Reset mid-burst (addr=0, count=3), rst_n=0 between clock edges after beat 1 -> wr_en goes to 0000 immediately. After release: IDLE, no further beats, and a new single write (addr=1) gives wr_en=0010.

Source files
------------

// File: rtl/regfile_burst_decoder.sv
// Register-file write-port decoder: accepts a burst request over valid/ready and
// issues one one-hot write enable per cycle over consecutive, wrapping addresses.
module regfile_burst_decoder #(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ZERO_PROTECT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [ADDR_W-1:0]        req_count,
    input  logic [DATA_W-1:0]        req_data,
    output logic [(1<<ADDR_W)-1:0]   wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cur_addr, cur_addr_n;
    logic [ADDR_W-1:0]   remaining, remaining_n;
    logic [DATA_W-1:0]   burst_data, burst_data_n;
    logic [DEPTH-1:0]    wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [DATA_W-1:0]   wr_data_n;
    logic                protect_beat;

    // Handshake and activity flags are pure decodes of the state register.
    assign req_ready = (state == IDLE);
    assign busy      = (state == BURST);

    assign protect_beat = (ZERO_PROTECT != 0) && (cur_addr == '0);

    // State and registered outputs; reset clears wr_en immediately, aborting any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            burst_data <= '0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            cur_addr   <= cur_addr_n;
            remaining  <= remaining_n;
            burst_data <= burst_data_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
        end
    end

    // Next-state and beat generation; wr_en defaults to zero on every non-beat edge.
    always_comb begin
        state_n      = state;
        cur_addr_n   = cur_addr;
        remaining_n  = remaining;
        burst_data_n = burst_data;
        wr_en_n      = '0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_n   = req_addr;
                    remaining_n  = req_count;
                    burst_data_n = req_data;
                    state_n      = BURST;
                end
            end
            BURST: begin
                if (en) begin
                    if (!protect_beat) begin
                        wr_en_n = DEPTH'(1) << cur_addr;
                    end
                    wr_addr_n  = cur_addr;
                    wr_data_n  = burst_data;
                    cur_addr_n = cur_addr + ADDR_W'(1);
                    if (remaining == '0) begin
                        state_n = IDLE;
                    end else begin
                        remaining_n = remaining - ADDR_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_burst_decoder.sv
// Bench for regfile_burst_decoder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a beat-queue model.
module tb_regfile_burst_decoder;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [ADDR_W-1:0] req_count = '0;
    logic [DATA_W-1:0] req_data = '0;

    logic              ready0, busy0, ready1, busy1;
    logic [DEPTH-1:0]  wr_en0, wr_en1;
    logic [ADDR_W-1:0] wr_addr0, wr_addr1;
    logic [DATA_W-1:0] wr_data0, wr_data1;

    int total = 0;
    int bad   = 0;

    regfile_burst_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_PROTECT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(ready0),
        .req_addr(req_addr), .req_count(req_count), .req_data(req_data),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0)
    );

    regfile_burst_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_PROTECT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(ready1),
        .req_addr(req_addr), .req_count(req_count), .req_data(req_data),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Model: an accepted request becomes a queue of beat addresses; each enabled edge pops one.
    int               beats[$];
    logic [DATA_W-1:0] m_data  = '0;
    logic [DEPTH-1:0]  exp_en0 = '0;
    logic [DEPTH-1:0]  exp_en1 = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats.delete();
            exp_en0  = '0;
            exp_en1  = '0;
            exp_addr = '0;
            exp_data = '0;
            m_data   = '0;
        end else begin
            exp_en0 = '0;
            exp_en1 = '0;
            if (beats.size() == 0) begin
                if (req_valid) begin
                    for (int i = 0; i <= int'(req_count); i++)
                        beats.push_back((int'(req_addr) + i) % DEPTH);
                    m_data = req_data;
                end
            end else if (en) begin
                int a;
                a = beats.pop_front();
                exp_en0  = DEPTH'(1) << a;
                exp_en1  = (a == 0) ? '0 : DEPTH'(1) << a;
                exp_addr = ADDR_W'(a);
                exp_data = m_data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("m_wr_en0",  32'(wr_en0),   32'(exp_en0));
            chk("m_wr_en1",  32'(wr_en1),   32'(exp_en1));
            chk("m_wr_addr0", 32'(wr_addr0), 32'(exp_addr));
            chk("m_wr_addr1", 32'(wr_addr1), 32'(exp_addr));
            chk("m_wr_data0", 32'(wr_data0), 32'(exp_data));
            chk("m_wr_data1", 32'(wr_data1), 32'(exp_data));
            chk("m_ready0",  32'(ready0),   32'(beats.size() == 0));
            chk("m_busy1",   32'(busy1),    32'(beats.size() != 0));
            chk("m_onehot0", 32'($countones(wr_en0) <= 1), 32'(1));
        end
    end

    task automatic issue(input int a, input int c, input int d);
        @(negedge clk);
        req_addr  = ADDR_W'(a);
        req_count = ADDR_W'(c);
        req_data  = DATA_W'(d);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [DEPTH-1:0] seq[3];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_en",   32'(wr_en0),   32'h0);
        chk("rst_wr_addr", 32'(wr_addr0), 32'h0);
        chk("rst_wr_data", 32'(wr_data0), 32'h0);
        chk("rst_ready",   32'(ready0),   32'h1);
        chk("rst_busy",    32'(busy0),    32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_wr_en", 32'(wr_en0), 32'h0);
        chk("idle_ready", 32'(ready0), 32'h1);

        // Single write
        issue(2, 0, 'hA5);
        chk("single_busy", 32'(busy0), 32'h1);
        @(negedge clk);
        chk("single_en",    32'(wr_en0),   32'b0100);
        chk("single_addr",  32'(wr_addr0), 32'h2);
        chk("single_data",  32'(wr_data0), 32'hA5);
        chk("single_ready", 32'(ready0),   32'h1);
        @(negedge clk);
        chk("single_after_en",   32'(wr_en0),   32'h0);
        chk("single_after_data", 32'(wr_data0), 32'hA5);
        chk("single_after_busy", 32'(busy0),    32'h0);

        // Wrap burst with a competing request offered while busy
        seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010;
        issue(3, 2, 'h3C);
        req_addr = 2'd1; req_count = 2'd0; req_data = 8'h77; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrap_en", 32'(wr_en0), 32'(seq[i]));
            chk("wrap_ready", 32'(ready0), (i == 2) ? 32'h1 : 32'h0);
            if (i == 1) req_valid = 1'b0;
        end
        @(negedge clk);
        chk("wrap_nosecond_en",   32'(wr_en0), 32'h0);
        chk("wrap_nosecond_busy", 32'(busy0),  32'h0);

        // Stall for two cycles after the second beat
        issue(0, 3, 'h11);
        @(negedge clk);
        chk("stall_b0", 32'(wr_en0), 32'b0001);
        @(negedge clk);
        chk("stall_b1", 32'(wr_en0), 32'b0010);
        en = 1'b0;
        @(negedge clk);
        chk("stall_z0", 32'(wr_en0), 32'h0);
        chk("stall_busy0", 32'(busy0), 32'h1);
        @(negedge clk);
        chk("stall_z1", 32'(wr_en0), 32'h0);
        chk("stall_hold_addr", 32'(wr_addr0), 32'h1);
        en = 1'b1;
        @(negedge clk);
        chk("stall_b2", 32'(wr_en0), 32'b0100);
        @(negedge clk);
        chk("stall_b3", 32'(wr_en0), 32'b1000);

        // Register-0 protection on the second instance
        issue(3, 1, 'hFF);
        @(negedge clk);
        chk("zp_b0", 32'(wr_en1), 32'b1000);
        @(negedge clk);
        chk("zp_b1_en",   32'(wr_en1),   32'h0);
        chk("zp_b1_addr", 32'(wr_addr1), 32'h0);
        chk("zp_busy",    32'(busy1),    32'h0);
        chk("zp_unprot",  32'(wr_en0),   32'b0001);

        // Asynchronous reset in the middle of a burst
        issue(0, 3, 'h5A);
        @(negedge clk);
        chk("rmid_b0", 32'(wr_en0), 32'b0001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_en",    32'(wr_en0), 32'h0);
        chk("rmid_busy",  32'(busy0),  32'h0);
        chk("rmid_ready", 32'(ready0), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rmid_nobeat", 32'(wr_en0), 32'h0);
        end
        issue(1, 0, 'h42);
        @(negedge clk);
        chk("rmid_new", 32'(wr_en0), 32'b0010);

        // Randomized traffic, including occasional reset pulses
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 2) == 0);
            req_addr  = ADDR_W'($urandom);
            req_count = ADDR_W'($urandom);
            req_data  = DATA_W'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
